// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types and default sizes for the round-robin register arbiter
package rr_arb_pkg;

  // Default number of requesters and shared register width
  localparam int RR_DEF_N = 4;
  localparam int RR_DEF_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner search starting at a pointer
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N  = RR_DEF_N,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx
);

  logic [PW-1:0] w_j;
  logic          w_found;

  // Walk upward from the pointer with wrap; the first set request wins
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 0; k < N; k++) begin
      w_j = PW'((int'(i_ptr) + k) % N);
      if (!w_found && i_req[w_j]) begin
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_reg_arbiter.sv
// rtl/rr_reg_arbiter.sv - round-robin arbiter owning a shared register; optional grant lock under RR_ARB_LOCK_EN
module rr_reg_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N = RR_DEF_N,
  parameter int W = RR_DEF_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
`ifdef RR_ARB_LOCK_EN
  input  logic [N-1:0]   lock,
`endif
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   q,
  output logic           upd,
  output logic           busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_gnt;
  logic [N-1:0]  w_gnt_nxt;
  logic [W-1:0]  r_q;
  logic [W-1:0]  w_q_nxt;
  logic          r_upd;
  logic          w_upd_nxt;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic [PW-1:0] r_win;
  logic [PW-1:0] w_win_nxt;

  logic [N-1:0]  w_pick_gnt;
  logic [PW-1:0] w_pick_idx;
  logic [W-1:0]  w_win_data;
  logic          w_wr;
  logic          w_hold;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx)
  );

  // The current winner still wants to write only while its request stays up
  assign w_wr = req[r_win];

`ifdef RR_ARB_LOCK_EN
  assign w_hold = w_wr && lock[r_win];
`else
  assign w_hold = 1'b0;
`endif

  // Select the winner's slice of the flat write bus
  always_comb begin
    w_win_data = '0;
    for (int i = 0; i < N; i++) begin
      if (r_win == PW'(i)) begin
        w_win_data = wdata[i*W +: W];
      end
    end
  end

  // Next-state and next-output logic for the IDLE/GRANT machine
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_q_nxt     = r_q;
    w_upd_nxt   = 1'b0;
    w_ptr_nxt   = r_ptr;
    w_win_nxt   = r_win;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = w_pick_gnt;
          w_win_nxt   = w_pick_idx;
        end
      end
      GRANT: begin
        if (w_wr) begin
          w_q_nxt   = w_win_data;
          w_upd_nxt = 1'b1;
        end
        if (!w_hold) begin
          // Pointer moves past the winner even when its write was cancelled
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_ptr_nxt   = (r_win == PW'(N-1)) ? '0 : r_win + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // State register; reset also aborts any write in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_q     <= '0;
      r_upd   <= 1'b0;
      r_ptr   <= '0;
      r_win   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_q     <= w_q_nxt;
      r_upd   <= w_upd_nxt;
      r_ptr   <= w_ptr_nxt;
      r_win   <= w_win_nxt;
    end
  end

  assign gnt  = r_gnt;
  assign q    = r_q;
  assign upd  = r_upd;
  assign busy = (r_state == GRANT);

endmodule

// File: doc/rr_reg_arbiter.md
RR_REG_ARBITER -- requirements
Module: rr_reg_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters (2..8).
REQ-002 Parameter W, default 8, width of the shared register.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port req  input  N  per-requester write request, level, bit i = requester i.
REQ-006 Port wdata  input  N*W  flat write data; requester i owns bits [i*W +: W].
REQ-007 Port gnt  output  N  registered one-hot grant; all zero when nothing is granted.
REQ-008 Port q  output  W  shared register contents.
REQ-009 Port upd  output  1  registered one-cycle pulse, high the cycle after q changes.
REQ-010 Port busy  output  1  high whenever the state is GRANT.

Function
REQ-011 The block SHALL be a two-state FSM: IDLE, GRANT.
REQ-012 In IDLE with req nonzero, the next edge SHALL enter GRANT and set gnt to one-hot(winner).
REQ-013 The winner SHALL be the first set req bit searching upward from pointer ptr, wrapping N-1 -> 0.
REQ-014 In IDLE with req all zero, the block SHALL stay in IDLE with gnt zero and ptr unchanged.
REQ-015 At the edge ending a GRANT cycle with req[winner] high, q SHALL load wdata slice of the winner and upd SHALL be 1 for the next cycle.
REQ-016 If req[winner] is low during GRANT, the write SHALL be cancelled: q holds and upd stays 0.
REQ-017 On leaving GRANT, ptr SHALL become (winner+1) mod N, whether or not the write was cancelled.
REQ-018 Without a lock, GRANT SHALL last exactly one cycle and then return to IDLE, with gnt cleared on the same edge.
REQ-019 Request-to-write latency SHALL therefore be 2 cycles, and peak throughput one write per 2 cycles.
REQ-020 Requests arriving during GRANT SHALL be sampled only in the following IDLE cycle.
REQ-021 gnt SHALL never have more than one bit set, and SHALL be nonzero only in GRANT.

Reset
REQ-022 rst high at a rising edge SHALL force state IDLE, gnt=0, q=0, upd=0, busy=0, ptr=0.
REQ-023 rst asserted during GRANT SHALL abort the write: q goes to 0, not to wdata.
REQ-024 The first request after reset SHALL use ptr=0, so requester 0 has top priority.

Configuration
REQ-025 With macro RR_ARB_LOCK_EN defined, the block SHALL add input port lock (N bits).
REQ-026 Under RR_ARB_LOCK_EN, in GRANT with req[winner] and lock[winner] high, the block SHALL stay in GRANT with gnt held and write q every cycle, pulsing upd for each write.
REQ-027 Under RR_ARB_LOCK_EN, when lock[winner] drops, the block SHALL perform the final write and leave GRANT per REQ-017/018.
REQ-028 Under RR_ARB_LOCK_EN, when req[winner] drops, the block SHALL apply REQ-016 whatever the state of lock.
REQ-029 Without RR_ARB_LOCK_EN, there SHALL be no lock port and GRANT SHALL always be one cycle.

Structure
REQ-030 Package rr_arb_pkg SHALL hold the state_t enum (IDLE, GRANT) and the default N and W constants.
REQ-031 Combinational sub-module rr_pick SHALL compute the one-hot winner from req and ptr.
REQ-032 rr_reg_arbiter SHALL instantiate rr_pick once and contain all sequential logic.

Verification (N=4, W=8)
REQ-033 The bench SHALL apply rst=1 for 2 cycles, then req=0001 with wdata[7:0]=0xA5, and check gnt=0001 one cycle later, then q=0xA5 and upd=1 the cycle after.
REQ-034 The bench SHALL hold req=1111 with wdata slices 0x10/0x21/0x32/0x43, and check grants in order 0001, 0010, 0100, 1000, 0001, with q following 0x10, 0x21, 0x32, 0x43.
REQ-035 The bench SHALL set ptr=3 via a prior grant to requester 2, apply req=1001, and check gnt=1000 first, then 0001 (wrap-around).
REQ-036 The bench SHALL drop req[1] during its GRANT cycle with q=0x55, and check q stays 0x55, upd=0, and the next grant starts search at requester 2.
REQ-037 The bench SHALL assert rst during GRANT with wdata=0xFF, and check q=0, gnt=0, and that the next request from requester 3 wins over 0 only if requester 0 is idle.
REQ-038 With RR_ARB_LOCK_EN, the bench SHALL hold req[2]=lock[2]=1 for 3 GRANT cycles with wdata 0x01, 0x02, 0x03, and check gnt stays 0100, upd is high for 3 consecutive cycles, and q ends at 0x03.
